apb_slave_regfile: RTL and testbench

// - APB completer at the far end of the AHB-to-APB bridge. It answers the transfers that
//   the bridge's APB interface drives out on Pselx/Penable/Pwrite/Paddr/Pwdata.
// - It holds a small register file: six read/write control registers, one read-only ID

---
 rtl/apb_slave_regfile_pkg.sv | 21 ++
 rtl/apb_slave_regfile_wait_counter.sv | 26 ++
 rtl/apb_slave_regfile.sv | 122 ++++++++++++
 tb/tb_apb_slave_regfile.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_slave_regfile_pkg.sv
// Shared types and constants for the APB completer register file.
package apb_slv_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam logic [2:0] REG_CTRL0 = 3'd0;
  localparam logic [2:0] REG_CTRL1 = 3'd1;
  localparam logic [2:0] REG_CTRL2 = 3'd2;
  localparam logic [2:0] REG_CTRL3 = 3'd3;
  localparam logic [2:0] REG_CTRL4 = 3'd4;
  localparam logic [2:0] REG_CTRL5 = 3'd5;
  localparam logic [2:0] REG_ID    = 3'd6;
  localparam logic [2:0] REG_STS   = 3'd7;

  localparam int unsigned NUM_RW_REGS = 6;

endpackage

// File: rtl/apb_slave_regfile_wait_counter.sv
// 4-bit loadable down-counter that paces the ACCESS wait states.
module apb_wait_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       dec,
  input  logic [3:0] load_val,
  output logic       zero
);

  logic [3:0] cnt;

  // Load takes priority over decrement; the count saturates at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/apb_slave_regfile.sv
// APB completer: six R/W control registers, a read-only ID and a live
// status register, programmable wait states and error responses.
module apb_slave_regfile
  import apb_slv_pkg::*;
#(
  parameter int unsigned SLV_ID      = 0,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
  input  logic         Hclk,
  input  logic         Hreset,
  input  logic [2:0]   Pselx,
  input  logic         Penable,
  input  logic         Pwrite,
  input  logic [31:0]  Paddr,
  input  logic [31:0]  Pwdata,
  output logic [31:0]  Prdata,
  output logic         Pready,
  output logic         Pslverr,
  input  logic [31:0]  sts_in,
  output logic [191:0] ctrl_out
);

  localparam logic [1:0] SEL_IDX  = 2'(SLV_ID);
  localparam logic [3:0] WAIT_VAL = 4'(WAIT_STATES);

  apb_state_e  st;
  logic        sel;
  logic        cnt_zero;
  logic        cnt_load;
  logic        cnt_dec;
  logic        complete;
  logic        wr_en;
  logic [2:0]  idx;
  logic        oor;
  logic [31:0] regs [NUM_RW_REGS];
  logic        unused_bits;

  assign sel         = Pselx[SEL_IDX];
  assign idx         = Paddr[4:2];
  assign oor         = |Paddr[7:5];
  assign unused_bits = ^{Pselx, Paddr[31:8], Paddr[1:0]};

  assign complete = (st == ACCESS) && sel && cnt_zero;
  // A reload happens on a fresh setup from IDLE and on a back-to-back setup
  // seen in the completion cycle.
  assign cnt_load = ((st == IDLE) && sel && !Penable) || (complete && !Penable);
  assign cnt_dec  = (st == ACCESS) && sel && !cnt_zero;

  apb_wait_counter u_wait (
    .clk      (Hclk),
    .rst      (Hreset),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (WAIT_VAL),
    .zero     (cnt_zero)
  );

  // Transfer sequencing; a dropped select in SETUP or ACCESS aborts to IDLE.
  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      st <= IDLE;
    end else begin
      case (st)
        IDLE:    if (sel && !Penable) st <= SETUP;
        SETUP:   st <= (sel && Penable) ? ACCESS : IDLE;
        ACCESS: begin
          if (!sel)          st <= IDLE;
          else if (cnt_zero) st <= Penable ? IDLE : SETUP;
        end
        default: st <= IDLE;
      endcase
    end
  end

  // Completion-cycle response and write strobe, decoded from the live inputs.
  always_comb begin
    Prdata  = '0;
    Pready  = 1'b0;
    Pslverr = 1'b0;
    wr_en   = 1'b0;
    if (complete) begin
      Pready = 1'b1;
      if (oor) begin
        Pslverr = 1'b1;
      end else begin
        case (idx)
          REG_CTRL0, REG_CTRL1, REG_CTRL2,
          REG_CTRL3, REG_CTRL4, REG_CTRL5: begin
            if (Pwrite) wr_en  = 1'b1;
            else        Prdata = regs[idx];
          end
          REG_ID: begin
            if (Pwrite) Pslverr = 1'b1;
            else        Prdata  = ID_VALUE;
          end
          REG_STS: begin
            if (Pwrite) Pslverr = 1'b1;
            else        Prdata  = sts_in;
          end
          default: Pslverr = 1'b1;
        endcase
      end
    end
  end

  // Register file; writes commit at the edge ending the completion cycle.
  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      for (int unsigned i = 0; i < NUM_RW_REGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[idx] <= Pwdata;
    end
  end

  // Flatten the register file onto ctrl_out, reg0 in the low word.
  always_comb begin
    ctrl_out = '0;
    for (int unsigned i = 0; i < NUM_RW_REGS; i++) ctrl_out[i*32 +: 32] = regs[i];
  end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench: two completers on one APB bus (slot 0 with 2 wait states, slot 1
// with none), checked against a transaction-level register model.
module tb_apb_slave_regfile;

  localparam logic [31:0] IDV = 32'hA5B0_0001;

  logic         Hclk = 1'b0;
  logic         Hreset;
  logic [2:0]   Pselx;
  logic         Penable;
  logic         Pwrite;
  logic [31:0]  Paddr;
  logic [31:0]  Pwdata;
  logic [31:0]  sts_in;

  logic [31:0]  rd_a, rd_b;
  logic         rdy_a, rdy_b, err_a, err_b;
  logic [191:0] ctrl_a, ctrl_b;

  bit           tgt;
  logic [31:0]  cur_rd;
  logic         cur_rdy, cur_err;
  logic [191:0] cur_ctrl;

  int nvec = 0;
  int nmis = 0;
  int a_rdy_seen = 0;

  logic [31:0] mreg [2][6];

  always #5 Hclk = ~Hclk;

  apb_slave_regfile #(.SLV_ID(0), .WAIT_STATES(2), .ID_VALUE(IDV)) u_ws2 (
    .Hclk(Hclk), .Hreset(Hreset), .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite),
    .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(rd_a), .Pready(rdy_a), .Pslverr(err_a),
    .sts_in(sts_in), .ctrl_out(ctrl_a)
  );

  apb_slave_regfile #(.SLV_ID(1), .WAIT_STATES(0), .ID_VALUE(IDV)) u_ws0 (
    .Hclk(Hclk), .Hreset(Hreset), .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite),
    .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(rd_b), .Pready(rdy_b), .Pslverr(err_b),
    .sts_in(sts_in), .ctrl_out(ctrl_b)
  );

  assign cur_rd   = tgt ? rd_b   : rd_a;
  assign cur_rdy  = tgt ? rdy_b  : rdy_a;
  assign cur_err  = tgt ? err_b  : err_a;
  assign cur_ctrl = tgt ? ctrl_b : ctrl_a;

  always @(negedge Hclk) if (rdy_a === 1'b1) a_rdy_seen++;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge Hclk);
    #1;
  endtask

  function automatic logic [191:0] mcat(input int t);
    logic [191:0] r;
    for (int i = 0; i < 6; i++) r[i*32 +: 32] = mreg[t][i];
    return r;
  endfunction

  // Reference behaviour of one completed transfer.
  task automatic model(input int t, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] sts, output logic [31:0] er, output logic ee);
    int idx;
    idx = int'(addr[4:2]);
    er = '0;
    ee = 1'b0;
    if (addr[7:5] != 3'd0) ee = 1'b1;
    else if (idx < 6) begin
      if (wr) mreg[t][idx] = wdata;
      else    er = mreg[t][idx];
    end else if (wr) ee = 1'b1;
    else if (idx == 6) er = IDV;
    else er = sts;
  endtask

  // One standard APB transfer: setup cycle, then Penable held until Pready.
  task automatic xfer(input bit t, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] sts, output logic [31:0] rdata, output logic err);
    int n;
    int ws;
    tgt = t;
    ws = t ? 0 : 2;
    Pselx = t ? 3'b010 : 3'b001;
    Penable = 1'b0; Pwrite = wr; Paddr = addr; Pwdata = wdata; sts_in = sts;
    #2 check("setup_ready", cur_rdy, 0);
    step;
    Penable = 1'b1;
    n = 0;
    forever begin
      #2;
      if (cur_rdy === 1'b1) break;
      n++;
      if (n > 20) begin
        nmis++;
        $display("FAIL timeout: no Pready after %0d cycles", n);
        break;
      end
      step;
    end
    rdata = cur_rd;
    err = cur_err;
    check("latency", n, ws + 1);
    step;
    Pselx = '0;
    Penable = 1'b0;
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] sts;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  vec_t vt [11];

  initial begin
    logic [31:0] rd, er;
    logic        e, ee;
    int          snap;

    vt[0]  = '{1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 32'h0,         32'h0,         1'b0};
    vt[1]  = '{1'b0, 32'h0000_0008, 32'h0,         32'h0,         32'hDEAD_BEEF, 1'b0};
    vt[2]  = '{1'b0, 32'h0000_0018, 32'h0,         32'h0,         IDV,           1'b0};
    vt[3]  = '{1'b0, 32'h0000_001C, 32'h0,         32'h0000_1234, 32'h0000_1234, 1'b0};
    vt[4]  = '{1'b1, 32'h0000_0018, 32'h0000_0001, 32'h0,         32'h0,         1'b1};
    vt[5]  = '{1'b1, 32'h0000_0040, 32'h0000_0002, 32'h0,         32'h0,         1'b1};
    vt[6]  = '{1'b0, 32'h0000_0040, 32'h0,         32'h0,         32'h0,         1'b1};
    vt[7]  = '{1'b0, 32'hFFFF_FF0B, 32'h0,         32'h0,         32'hDEAD_BEEF, 1'b0};
    vt[8]  = '{1'b1, 32'h0000_0000, 32'h1111_1111, 32'h0,         32'h0,         1'b0};
    vt[9]  = '{1'b0, 32'h0000_0014, 32'h0,         32'h0,         32'h0,         1'b0};
    vt[10] = '{1'b0, 32'h0000_0000, 32'h0,         32'h0,         32'h1111_1111, 1'b0};

    for (int t = 0; t < 2; t++) for (int i = 0; i < 6; i++) mreg[t][i] = '0;

    Hreset = 1'b1; Pselx = '0; Penable = 1'b0; Pwrite = 1'b0;
    Paddr = '0; Pwdata = '0; sts_in = '0; tgt = 1'b0;
    #2;
    check("rst_rdata", rd_a, 0);
    check("rst_ready", rdy_a, 0);
    check("rst_slverr", err_a, 0);
    check("rst_ctrl", ctrl_a, 0);
    step; step;
    Hreset = 1'b0;
    step;

    // Directed table against the 2-wait-state slot.
    for (int i = 0; i < 11; i++) begin
      xfer(1'b0, vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].sts, rd, e);
      check($sformatf("vec%0d_err", i), e, vt[i].exp_err);
      if (!vt[i].wr) check($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
      model(0, vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].sts, er, ee);
      check($sformatf("vec%0d_ctrl", i), ctrl_a, mcat(0));
    end
    check("ctrl_reg2", ctrl_a[95:64], 32'hDEAD_BEEF);

    // Back-to-back on the zero-wait slot: the next setup overlaps completion.
    tgt = 1'b1;
    Pselx = 3'b010; Penable = 1'b0; Pwrite = 1'b1; Paddr = 32'h04; Pwdata = 32'h0BAD_F00D;
    #2 check("b2b_c0_ready", rdy_b, 0);
    step; Penable = 1'b1;
    #2 check("b2b_c1_ready", rdy_b, 0);
    step; Penable = 1'b0;
    #2 check("b2b_c2_ready", rdy_b, 1);
    check("b2b_c2_err", err_b, 0);
    step; Penable = 1'b1; Paddr = 32'h0C; Pwdata = 32'h1357_9BDF;
    #2 check("b2b_c3_ready", rdy_b, 0);
    step; Penable = 1'b0;
    #2 check("b2b_c4_ready", rdy_b, 1);
    step; Penable = 1'b1; Pwrite = 1'b0; Paddr = 32'h04;
    #2 check("b2b_c5_ready", rdy_b, 0);
    step;
    #2 check("b2b_c6_ready", rdy_b, 1);
    check("b2b_c6_rdata", rd_b, 32'h0BAD_F00D);
    step; Pselx = '0; Penable = 1'b0;
    #2 check("b2b_idle_ready", rdy_b, 0);
    mreg[1][1] = 32'h0BAD_F00D;
    mreg[1][3] = 32'h1357_9BDF;
    check("b2b_ctrl", ctrl_b, mcat(1));
    step;

    // Abort on the 2-wait-state slot in the ACCESS cycle where cnt is 1.
    tgt = 1'b0;
    Pselx = 3'b001; Penable = 1'b0; Pwrite = 1'b1; Paddr = 32'h10; Pwdata = 32'hCAFE_CAFE;
    step; Penable = 1'b1;
    step;
    #2 check("abort_acc1_ready", rdy_a, 0);
    step; Pselx = '0;
    #2 check("abort_drop_ready", rdy_a, 0);
    step;
    #2 check("abort_idle_ready", rdy_a, 0);
    check("abort_ctrl", ctrl_a, mcat(0));
    xfer(1'b0, 1'b0, 32'h10, 32'h0, 32'h0, rd, e);
    check("abort_readback", rd, mreg[0][4]);

    // Wrong select: slot 0 must ignore a transfer addressed to slot 1.
    snap = a_rdy_seen;
    xfer(1'b1, 1'b1, 32'h00, 32'h7777_0000, 32'h0, rd, e);
    model(1, 1'b1, 32'h00, 32'h7777_0000, 32'h0, er, ee);
    check("wrongsel_no_ready", a_rdy_seen, snap);
    check("wrongsel_ctrl", ctrl_a, mcat(0));

    // Randomised traffic across both slots.
    for (int k = 0; k < 150; k++) begin
      bit          t, wr;
      logic [31:0] addr, wd, st;
      t  = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      addr = $urandom;
      addr[7:5] = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      wd = $urandom;
      st = $urandom;
      model(int'(t), wr, addr, wd, st, er, ee);
      xfer(t, wr, addr, wd, st, rd, e);
      check("rand_err", e, ee);
      if (!wr) check("rand_rdata", rd, er);
      tgt = t;
      #0 check("rand_ctrl", cur_ctrl, mcat(int'(t)));
    end

    // Reset asserted in the completion cycle of a write.
    mreg[0][2] = 32'h5A5A_5A5A;
    xfer(1'b0, 1'b1, 32'h08, 32'h5A5A_5A5A, 32'h0, rd, e);
    tgt = 1'b0;
    Pselx = 3'b001; Penable = 1'b0; Pwrite = 1'b1; Paddr = 32'h08; Pwdata = 32'h2468_ACE0;
    step; Penable = 1'b1;
    step; step; step;
    #1 Hreset = 1'b1;
    #1;
    check("midrst_ready", rdy_a, 0);
    check("midrst_rdata", rd_a, 0);
    check("midrst_slverr", err_a, 0);
    check("midrst_ctrl_a", ctrl_a, 0);
    check("midrst_ctrl_b", ctrl_b, 0);
    for (int t = 0; t < 2; t++) for (int i = 0; i < 6; i++) mreg[t][i] = '0;
    Pselx = '0; Penable = 1'b0;
    step;
    Hreset = 1'b0;
    step;
    xfer(1'b0, 1'b0, 32'h08, 32'h0, 32'h0, rd, e);
    check("postrst_reg2", rd, 0);
    check("postrst_err", e, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
